muldiv_unit: RTL and testbench

Iterative multiply/divide unit sitting between the register file read ports and its write port. It captures two source operands and a destination register select from the decode/execute stage. It computes a 64-bit product or a quotient/remainder pair over 32 cycles, then issues a single-cycle write request (wen/wsel/wdat) toward the register file write port. HI/LO results are held for mfhi/mflo-style reads.

---
 rtl/cpu_types_pkg.sv | 23 ++
 rtl/muldiv_core.sv | 38 +++
 rtl/muldiv_unit.sv | 127 ++++++++++++
 tb/tb_muldiv_unit.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/cpu_types_pkg.sv
// Shared CPU types; the muldiv additions here are used by muldiv_unit/muldiv_core.
// MULDIV_DIV_EN (defined elsewhere) enables the divide datapath in those modules.
package cpu_types_pkg;

  typedef logic [31:0] word_t;
  typedef logic [4:0]  regbits_t;

  localparam int unsigned MULDIV_CYCLES = 32;

  typedef enum logic [1:0] {
    MULT  = 2'd0,
    MULTU = 2'd1,
    DIV   = 2'd2,
    DIVU  = 2'd3
  } muldiv_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } muldiv_state_t;

endpackage

// File: rtl/muldiv_core.sv
// Single radix-2 step of the multiply/divide datapath (combinational).
// The restoring-divide step is only built when MULDIV_DIV_EN is defined.
module muldiv_core
  import cpu_types_pkg::*;
(
  input  logic        is_div,
  input  logic [63:0] acc,
  input  word_t       b,
  output logic [63:0] acc_next
);

  logic [32:0] sum;
`ifdef MULDIV_DIV_EN
  logic [32:0] top;
  logic [32:0] diff;
`else
  logic        unused_is_div;
  assign unused_is_div = is_div;
`endif

  // Multiply keeps the multiplier in acc[31:0] and the partial product in acc[63:32];
  // divide keeps the partial remainder in acc[63:32] and shifts quotient bits into acc[0].
  always_comb begin
    sum      = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, b} : '0);
    acc_next = {sum, acc[31:1]};
`ifdef MULDIV_DIV_EN
    top  = acc[63:31];
    diff = top - {1'b0, b};
    if (is_div) begin
      if (top >= {1'b0, b})
        acc_next = {diff[31:0], acc[30:0], 1'b1};
      else
        acc_next = {top[31:0], acc[30:0], 1'b0};
    end
`endif
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative 32-cycle multiply/divide unit with HI/LO and register-file writeback.
// Define MULDIV_DIV_EN to include DIV/DIVU; otherwise they raise a one-cycle illegal pulse.
module muldiv_unit
  import cpu_types_pkg::*;
(
  input  logic       CLK,
  input  logic       nRST,
  input  logic       start,
  input  muldiv_op_t op,
  input  word_t      opa,
  input  word_t      opb,
  input  regbits_t   dest,
  input  logic       flush,
  output logic       busy,
  output logic       done,
  output logic       wen,
  output regbits_t   wsel,
  output word_t      wdat,
  output word_t      hi,
  output word_t      lo,
  output logic       illegal
);

  muldiv_state_t state;
  logic [4:0]    count;
  logic [63:0]   acc, acc_next, prod;
  word_t         b, hi_q, lo_q, res_hi, res_lo, mag_a, mag_b, q, r;
  logic          sa, sb, is_div_q, illegal_q, neg, fire, supported;
  logic          sgn_a, sgn_b;
  regbits_t      dest_q;

  muldiv_core u_core (
    .is_div   (is_div_q),
    .acc      (acc),
    .b        (b),
    .acc_next (acc_next)
  );

  // Operands are iterated as magnitudes; signs are reapplied in DONE.
  always_comb begin
    sgn_a = ~op[0] & opa[31];
    sgn_b = ~op[0] & opb[31];
    mag_a = sgn_a ? -opa : opa;
    mag_b = sgn_b ? -opb : opb;
`ifdef MULDIV_DIV_EN
    supported = 1'b1;
`else
    supported = ~op[1];
`endif
  end

  always_comb begin
    neg    = sa ^ sb;
    prod   = neg ? -acc : acc;
    q      = acc[31:0];
    r      = acc[63:32];
    res_hi = prod[63:32];
    res_lo = prod[31:0];
    if (is_div_q) begin
      res_hi = sa ? -r : r;
      res_lo = (b == '0) ? '1 : (neg ? -q : q);
    end
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state     <= IDLE;
      count     <= '0;
      acc       <= '0;
      b         <= '0;
      sa        <= 1'b0;
      sb        <= 1'b0;
      is_div_q  <= 1'b0;
      dest_q    <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      illegal_q <= 1'b0;
    end else begin
      illegal_q <= 1'b0;
      if (flush) begin
        state <= IDLE;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              if (supported) begin
                is_div_q <= op[1];
                sa       <= sgn_a;
                sb       <= sgn_b;
                acc      <= {32'b0, mag_a};
                b        <= mag_b;
                dest_q   <= dest;
                count    <= '0;
                state    <= BUSY;
              end else begin
                illegal_q <= 1'b1;
              end
            end
          end
          BUSY: begin
            acc   <= acc_next;
            count <= count + 5'd1;
            if (count == 5'(MULDIV_CYCLES - 1))
              state <= DONE;
          end
          DONE: begin
            hi_q  <= res_hi;
            lo_q  <= res_lo;
            state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign fire    = (state == DONE) && !flush;
  assign busy    = (state != IDLE);
  assign done    = fire;
  assign wen     = fire && (dest_q != '0);
  assign wsel    = fire ? dest_q : '0;
  assign wdat    = fire ? res_lo : '0;
  assign hi      = hi_q;
  assign lo      = lo_q;
  assign illegal = illegal_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit; divide cases run when MULDIV_DIV_EN is defined.
module tb_muldiv_unit;
  import cpu_types_pkg::*;

  logic       CLK = 1'b0;
  logic       nRST, start, flush;
  logic [1:0] opv;
  muldiv_op_t op;
  word_t      opa, opb, wdat, hi, lo;
  regbits_t   dest, wsel;
  logic       busy, done, wen, illegal;

  typedef struct {
    logic     wen;
    regbits_t wsel;
    word_t    wdat;
    word_t    hi;
    word_t    lo;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;

  assign op = muldiv_op_t'(opv);

  muldiv_unit dut (
    .CLK(CLK), .nRST(nRST), .start(start), .op(op), .opa(opa), .opb(opb),
    .dest(dest), .flush(flush), .busy(busy), .done(done), .wen(wen),
    .wsel(wsel), .wdat(wdat), .hi(hi), .lo(lo), .illegal(illegal)
  );

  always #5 CLK = ~CLK;

  task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(logic [1:0] o, word_t a, word_t bb, regbits_t d);
    exp_t        e;
    longint      sa, sbv;
    logic [63:0] p;
    sa  = longint'($signed(a));
    sbv = longint'($signed(bb));
    p   = '0;
    case (o)
      2'd0: p = 64'(sa * sbv);
      2'd1: p = {32'b0, a} * {32'b0, bb};
      2'd2: p = (bb == 0) ? {a, 32'hFFFF_FFFF}
                          : {32'(sa % sbv), 32'(sa / sbv)};
      default: p = (bb == 0) ? {a, 32'hFFFF_FFFF} : {a % bb, a / bb};
    endcase
    e.hi   = p[63:32];
    e.lo   = p[31:0];
    e.wen  = (d != 0);
    e.wsel = d;
    e.wdat = p[31:0];
    return e;
  endfunction

  task automatic drive(logic [1:0] o, word_t a, word_t bb, regbits_t d);
    start = 1'b1; opv = o; opa = a; opb = bb; dest = d;
  endtask

  // Consumes the accept edge, then follows the operation to completion.
  task automatic collect();
    int   cyc, bc;
    bit   got;
    exp_t e;
    @(posedge CLK); #1 start = 1'b0;
    cyc = 0; bc = 0; got = 0;
    while (cyc < 40 && !got) begin
      @(negedge CLK);
      cyc++;
      if (busy) bc++;
      if (done) begin
        got = 1;
        e = sb.pop_front();
        check("done_cycle", 64'(cyc), 64'd33);
        check("wen", 64'(wen), 64'(e.wen));
        check("wsel", 64'(wsel), 64'(e.wsel));
        check("wdat", 64'(wdat), 64'(e.wdat));
      end
    end
    if (!got) begin
      check("done_timeout", 64'd0, 64'd1);
      if (sb.size() > 0) void'(sb.pop_front());
    end else begin
      @(negedge CLK);
      if (busy) bc++;
      check("busy_cycles", 64'(bc), 64'd33);
      check("done_pulse", 64'(done), 64'd0);
      check("hi", 64'(hi), 64'(e.hi));
      check("lo", 64'(lo), 64'(e.lo));
    end
  endtask

  task automatic run(logic [1:0] o, word_t a, word_t bb, regbits_t d);
    @(negedge CLK);
    drive(o, a, bb, d);
    sb.push_back(model(o, a, bb, d));
    collect();
  endtask

  task automatic check_reset_outputs(string tag);
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_done"}, 64'(done), 64'd0);
    check({tag, "_wen"}, 64'(wen), 64'd0);
    check({tag, "_wsel"}, 64'(wsel), 64'd0);
    check({tag, "_wdat"}, 64'(wdat), 64'd0);
    check({tag, "_hilo"}, {hi, lo}, 64'd0);
    check({tag, "_illegal"}, 64'(illegal), 64'd0);
  endtask

  initial begin
    word_t hs, ls;
    bit    seen;
    nRST = 1'b0; start = 1'b0; flush = 1'b0; opv = '0; opa = '0; opb = '0; dest = '0;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    check_reset_outputs("rst0");
    nRST = 1'b1;

    run(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd5);
    run(2'd0, 32'hFFFF_FFFD, 32'd7, 5'd3);
    run(2'd1, 32'd6, 32'd7, 5'd0);
    for (int i = 0; i < 4; i++) begin
`ifdef MULDIV_DIV_EN
      run(2'($urandom_range(0, 3)), $urandom, $urandom, 5'($urandom_range(0, 31)));
`else
      run(2'($urandom_range(0, 1)), $urandom, $urandom, 5'($urandom_range(0, 31)));
`endif
    end

`ifdef MULDIV_DIV_EN
    run(2'd2, 32'hFFFF_FFF9, 32'd2, 5'd9);
    run(2'd3, 32'd10, 32'd0, 5'd4);
    run(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 5'd1);
    run(2'd2, 32'hFFFF_FFF7, 32'd0, 5'd2);
`else
    hs = hi; ls = lo;
    @(negedge CLK);
    drive(2'd2, 32'd100, 32'd7, 5'd6);
    @(posedge CLK); #1 start = 1'b0;
    @(negedge CLK);
    check("illegal_pulse", 64'(illegal), 64'd1);
    check("illegal_busy", 64'(busy), 64'd0);
    @(negedge CLK);
    check("illegal_clear", 64'(illegal), 64'd0);
    check("illegal_idle", {63'd0, busy | done | wen}, 64'd0);
    check("illegal_hilo", {hi, lo}, {hs, ls});
`endif

    // Flush during BUSY, then a fresh start accepted right after.
    hs = hi; ls = lo; seen = 0;
    @(negedge CLK);
    drive(2'd1, 32'd123, 32'd456, 5'd7);
    @(posedge CLK); #1 start = 1'b0;
    for (int c = 1; c <= 11; c++) begin
      @(negedge CLK);
      seen |= done | wen;
      if (c == 10) flush = 1'b1;
      if (c == 11) begin
        flush = 1'b0;
        check("flush_busy", 64'(busy), 64'd0);
        check("flush_nodone", 64'(seen), 64'd0);
        check("flush_hilo", {hi, lo}, {hs, ls});
        drive(2'd0, 32'hFFFF_FFF0, 32'd3, 5'd8);
        sb.push_back(model(2'd0, 32'hFFFF_FFF0, 32'd3, 5'd8));
      end
    end
    collect();

    // Reset in the middle of an operation.
    @(negedge CLK);
`ifdef MULDIV_DIV_EN
    drive(2'd2, 32'd1000, 32'd7, 5'd11);
`else
    drive(2'd0, 32'd1000, 32'd7, 5'd11);
`endif
    @(posedge CLK); #1 start = 1'b0;
    repeat (20) @(negedge CLK);
    nRST = 1'b0;
    @(negedge CLK);
    check_reset_outputs("rst_mid");
    nRST = 1'b1;
    run(2'd1, 32'd9, 32'd9, 5'd12);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
